// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter encodings and table geometry for the branch predictor
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam int BP_ENTRIES = 32;
  localparam int BP_TAG_W   = 5;
  localparam int BP_IDX_LSB = 2;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_LSB = BP_IDX_LSB + BP_IDX_W;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-state logic
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t state_i,
  input  logic taken_i,
  output ctr_t next_o
);

  always_comb begin
    next_o = state_i;
    if (taken_i) begin
      if (state_i != ST) next_o = ctr_t'(state_i + 2'd1);
    end else begin
      if (state_i != SNT) next_o = ctr_t'(state_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, comb lookup, 1-cycle update
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int TAG_W   = BP_TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_IF,
  output logic        prediction,
  output logic [31:0] predicted_target,
  input  logic        update_en,
  input  logic [31:0] pc_ID,
  input  logic        taken_ID,
  input  logic [31:0] target_ID,
  input  logic        stall_ID
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LSB = BP_IDX_LSB + IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];

  logic [IDX_W-1:0] idx_if, idx_id;
  logic [TAG_W-1:0] tag_if, tag_id;
  logic             hit_if, hit_id, we;
  logic [TAG_W-1:0] tag_d;
  logic [31:0]      target_d;
  ctr_t             ctr_d, ctr_inc;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{pc_IF, pc_ID};

  assign idx_if = pc_IF[IDX_W+BP_IDX_LSB-1:BP_IDX_LSB];
  assign tag_if = pc_IF[TAG_LSB+TAG_W-1:TAG_LSB];
  assign idx_id = pc_ID[IDX_W+BP_IDX_LSB-1:BP_IDX_LSB];
  assign tag_id = pc_ID[TAG_LSB+TAG_W-1:TAG_LSB];

  // Lookup reads only registered state, so a same-cycle update is seen next cycle.
  assign hit_if           = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign prediction       = hit_if && ctr_q[idx_if][1];
  assign predicted_target = prediction ? target_q[idx_if] : 32'b0;

  assign hit_id = valid_q[idx_id] && (tag_q[idx_id] == tag_id);

  sat_counter2 u_sat_counter2 (
    .state_i (ctr_q[idx_id]),
    .taken_i (taken_ID),
    .next_o  (ctr_inc)
  );

  // Not-taken misses leave the table alone; taken misses evict the occupant.
  always_comb begin
    we       = update_en && !stall_ID && (hit_id || taken_ID);
    tag_d    = tag_id;
    target_d = taken_ID ? target_ID : target_q[idx_id];
    ctr_d    = hit_id ? ctr_inc : WT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (we) begin
      valid_q[idx_id]  <= 1'b1;
      tag_q[idx_id]    <= tag_d;
      target_q[idx_id] <= target_d;
      ctr_q[idx_id]    <= ctr_d;
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 32, number of predictor/BTB entries (power of two).
REQ-002 SHALL have parameter TAG_W, default 5, number of PC tag bits stored per entry.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pc_IF  input  32  byte PC of the instruction being fetched.
REQ-006 SHALL have port prediction  output  1  predicted taken for pc_IF; feeds the hazard unit and IF mux.
REQ-007 SHALL have port predicted_target  output  32  BTB target for pc_IF.
REQ-008 SHALL have port update_en  input  1  a branch resolved in ID this cycle (the `branch` signal).
REQ-009 SHALL have port pc_ID  input  32  byte PC of the resolving branch.
REQ-010 SHALL have port taken_ID  input  1  actual outcome of the branch (the `branchValid` signal).
REQ-011 SHALL have port target_ID  input  32  resolved branch target.
REQ-012 SHALL have port stall_ID  input  1  load-use stall in ID (ld_has_hazard); suppresses updates.

Function
REQ-013 SHALL index entries with idx = pc[IDX_W+1:2], where IDX_W = log2(ENTRIES); tag = pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-014 SHALL hold per entry: valid (1), tag (TAG_W), target (32), 2-bit counter SNT=00, WNT=01, WT=10, ST=11.
REQ-015 SHALL drive prediction combinationally = valid[idx] AND tag match AND counter[idx][1]; otherwise 0.
REQ-016 SHALL drive predicted_target = target[idx] when prediction=1, else 32'b0.
REQ-017 SHALL perform an update on a rising edge only when update_en=1 and stall_ID=0.
REQ-018 Hit update (valid and tag match): counter saturating +1 if taken_ID=1, saturating -1 if taken_ID=0; target overwritten with target_ID only when taken_ID=1.
REQ-019 Miss update with taken_ID=1: allocate entry (valid=1, tag, target=target_ID, counter=WT), replacing any previous occupant.
REQ-020 Miss update with taken_ID=0: no state change.
REQ-021 SHALL saturate: ST+taken stays ST; SNT+not-taken stays SNT; no wrap-around.
REQ-022 Same-cycle read and update of the same idx: prediction/predicted_target SHALL reflect the pre-update state; the new state is visible the next cycle.
REQ-023 SHALL have a lookup latency of 0 cycles and an update latency of 1 cycle; at most one update per cycle.

Reset
REQ-024 On rst=0, all entries SHALL asynchronously clear: valid=0, tag=0, target=0, counter=WNT.
REQ-025 During reset, prediction=0 and predicted_target=0; an update coincident with reset SHALL be discarded.
REQ-026 Reset deassertion mid-operation SHALL leave the table empty; the first update is accepted at the first rising edge with rst=1.

Structure
REQ-027 Shared package bp_pkg SHALL hold the counter encodings (SNT/WNT/WT/ST), default ENTRIES, TAG_W, and the idx/tag slicing widths.
REQ-028 The 2-bit saturating next-state logic SHALL be a sub-module named sat_counter2 (inputs: state, taken; output: next state), instantiated once on the update path.
REQ-029 SHALL contain no memory macros; the table is flops with one write port and one read port.

Verification
REQ-030 Reset, then pc_IF=0x40 -> prediction=0, predicted_target=0.
REQ-031 Update pc_ID=0x40, taken=1, target=0x100 -> next cycle pc_IF=0x40 gives prediction=1, target=0x100; counter=WT.
REQ-032 Three not-taken updates to 0x40 after REQ-031 -> first gives WNT, prediction=0; counter saturates at SNT; target stays 0x100.
REQ-033 Alias: pc 0x40 allocated, then taken update at 0x40+(ENTRIES*4)=0xC0 -> 0x40 misses (prediction=0), 0xC0 hits.
REQ-034 update_en=1 with stall_ID=1 -> no state change; same-cycle read/update of idx returns the old value; ST plus taken stays ST.
REQ-035 Assert rst=0 mid-run with update_en=1 -> all entries cleared, outputs 0 immediately, without waiting for a clock edge.
